multicycle_control: RTL
=======================

# multicycle_control

Moore-style sequencer for the multi-cycle MIPS datapath. It replaces the single-cycle combinational control on a datapath that shares one memory port and one ALU across cycles. It steps each instruction through fetch, decode, execute, memory and writeback states and drives every datapath mux select and write enable. It also stalls on a memory ready handshake, traps on unsupported opcodes, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- instrn_opcode  in  6  opcode field from the instruction register; valid from DECODE onward
- zero_out  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- iord  out  1  memory address select: 0 = PC, 1 = ALU-out register
- mem_write_en  out  1  data memory write strobe
- ir_write_en  out  1  load the instruction register
- pc_write_en  out  1  load the PC
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALU-out register (branch target), 2 = jump address
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = read_data1
- alu_src_b  out  2  ALU operand B: 0 = read_data2, 1 = constant 4, 2 = sign_ext_out, 3 = sign_ext_out<<2
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct
- reg_write_en  out  1  register file write enable
- reg_dst  out  1  destination register: 0 = instrn[20:16], 1 = instrn[15:11]
- mem_to_reg  out  1  register write data: 0 = ALU-out register, 1 = memory data register
- trap  out  1  sticky flag for an unsupported opcode
- retired_count  out  CNT_W  count of completed instructions

## Operation
Supported opcodes: 0x00 R-type, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x02 J. Any other opcode goes to TRAP.

Outputs are decoded from the state register, with two exceptions: the mem_ready qualification and the zero_out qualification below. Any output not listed for a state is 0.

States and outputs:
- RESET: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, iord=0.
  - While mem_ready=1: ir_write_en=1, pc_write_en=1, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0.
  - Next state is DECODE when mem_ready=1; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=00. This computes the branch target into the ALU-out register.
  - Next state by opcode: 0x00 → EXEC, 0x23/0x2B → MEM_ADDR, 0x04 → BRANCH, 0x02 → JUMP, other → TRAP.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=10. Next state is ALU_WB.
- ALU_WB: reg_write_en=1, reg_dst=1, mem_to_reg=0. Retires the instruction. Next state is FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=00.
  - Next state is MEM_RD for opcode 0x23, MEM_WR for 0x2B.
- MEM_RD: mem_req=1, iord=1. Next state is MEM_WB when mem_ready=1; otherwise stay in MEM_RD.
- MEM_WB: reg_write_en=1, reg_dst=0, mem_to_reg=1. Retires the instruction. Next state is FETCH.
- MEM_WR: mem_req=1, iord=1, mem_write_en=1.
  - mem_write_en is held high for the whole request, until mem_ready=1.
  - Retires the instruction on the mem_ready cycle, then goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1, pc_write_en=zero_out. Retires the instruction. Next state is FETCH.
- JUMP: pc_src=2, pc_write_en=1. Retires the instruction. Next state is FETCH.
- TRAP: all outputs 0 except trap=1. Stays in TRAP until rst_n=0.

Retired counter:
- retired_count increments by 1 on each retiring cycle.
- It wraps from 2^CNT_W−1 to 0.
- Reset value is 0.

## Timing
- Reset: rst_n=0 at a rising edge sets state=RESET, retired_count=0 and trap=0. All outputs are 0 in the following cycle.
  - Reset asserted mid-instruction aborts it: no retire, no further write strobes. This also holds mid-wait in FETCH, MEM_RD or MEM_WR.
  - The first FETCH begins one cycle after rst_n returns to 1.
- Memory handshake: mem_req stays high until mem_ready=1 is sampled.
  - mem_ready seen while mem_req=0 is ignored.
  - A zero-wait access completes in one cycle. Each cycle with mem_ready=0 adds one cycle.
- Instruction latency with mem_ready tied to 1: R-type 4 cycles, LW 5, SW 4, BEQ 3, J 3.
- zero_out is sampled only in BRANCH, in the same cycle as the PC write.
- A retire and a counter wrap in the same cycle produce 0, with no flag.

## Structure
- Shared package multicycle_pkg holds:
  - the state enum;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - the alu_op, alu_src_b and pc_src encodings.
- The datapath mux owners import the same package.
- Implement as a single module with one state register, one next-state block, one output decode block and the counter. No sub-module is needed.

## Test plan
- Reset then R-type, mem_ready=1: RESET cycle has all outputs 0. FETCH, DECODE, EXEC and ALU_WB follow in consecutive cycles. reg_write_en=1 with reg_dst=1 in cycle 4. retired_count ends at 1.
- LW with mem_ready low for 2 cycles in both FETCH and MEM_RD: total 9 cycles. ir_write_en pulses once. mem_to_reg=1 and reg_write_en=1 in the final cycle.
- BEQ with zero_out=1, then BEQ with zero_out=0: pc_write_en=1 with pc_src=1 in the first BRANCH, and 0 in the second. Each takes 3 cycles.
- Opcode 0x3F: TRAP entered after DECODE. trap=1 and all strobes 0 for 20 or more cycles, no counter change. rst_n=0 clears trap.
- CNT_W=4, 16 back-to-back J instructions: retired_count goes 15 → 0. Each J takes 3 cycles with pc_src=2.
- rst_n=0 during a MEM_WR wait: next cycle is RESET with mem_write_en=0 and mem_req=0. retired_count=0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// ============================================================================
// multicycle_pkg
// Shared state, opcode and datapath-select encodings for the multi-cycle MIPS.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_RD1 = 1'b1;

  localparam logic [1:0] SRCB_RD2     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  function automatic state_e decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:     decode_next = S_EXEC;
      OP_LW, OP_SW: decode_next = S_MEM_ADDR;
      OP_BEQ:       decode_next = S_BRANCH;
      OP_J:         decode_next = S_JUMP;
      default:      decode_next = S_TRAP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control
// Moore sequencer driving the shared-memory, shared-ALU multi-cycle datapath.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       instrn_opcode,
  input  logic             zero_out,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_write_en,
  output logic             ir_write_en,
  output logic             pc_write_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write_en,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [CNT_W-1:0] retired_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = decode_next(instrn_opcode);
      S_EXEC:     state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: begin
        if (instrn_opcode == OP_LW)      state_d = S_MEM_RD;
        else if (instrn_opcode == OP_SW) state_d = S_MEM_WR;
        else                             state_d = S_TRAP;
      end
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_RESET;
    endcase
  end

  // Only mem_ready (FETCH, MEM_WR) and zero_out (BRANCH) leak through combinationally.
  always_comb begin
    mem_req      = 1'b0;
    iord         = 1'b0;
    mem_write_en = 1'b0;
    ir_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    pc_src       = PC_ALU;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RD2;
    alu_op       = ALU_ADD;
    reg_write_en = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    trap         = 1'b0;
    retire       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write_en = 1'b1;
          pc_write_en = 1'b1;
          alu_src_b   = SRCB_FOUR;
        end
      end
      S_DECODE:   alu_src_b = SRCB_IMM_SH2;
      S_EXEC: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        reg_write_en = 1'b1;
        reg_dst      = 1'b1;
        retire       = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_en = 1'b1;
        mem_to_reg   = 1'b1;
        retire       = 1'b1;
      end
      S_MEM_WR: begin
        mem_req      = 1'b1;
        iord         = 1'b1;
        mem_write_en = 1'b1;
        retire       = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_RD1;
        alu_op      = ALU_SUB;
        pc_src      = PC_ALUOUT;
        pc_write_en = zero_out;
        retire      = 1'b1;
      end
      S_JUMP: begin
        pc_src      = PC_JUMP;
        pc_write_en = 1'b1;
        retire      = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  always_comb count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign retired_count = count_q;

endmodule

`default_nettype wire
